// File: rtl/pwm_ramp_ctrl_if.sv
// Command channel of the PWM ramp controller: valid/ready handshake
// carrying the ramp target, step size and per-update hold count.
interface pwm_ramp_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_target;
    logic [7:0] cmd_step;
    logic [7:0] cmd_hold;

    modport master (
        output cmd_valid, cmd_target, cmd_step, cmd_hold,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_target, cmd_step, cmd_hold,
        output cmd_ready
    );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// PWM duty ramp sequencer. Runs a period counter matching the PWM
// generator, accepts ramp commands and walks duty_out toward the target
// in saturating steps, changing duty only on the edge where the period
// counter wraps so the PWM never sees a mid-period duty change.
module pwm_ramp_ctrl #(
    parameter int         PERIOD_BITS = 17,
    parameter logic [7:0] INIT_DUTY   = 8'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    pwm_ramp_ctrl_if.slave        cmd,
    input  logic                  abort,
    output logic [7:0]            duty_out,
    output logic                  period_end,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [PERIOD_BITS-1:0] cnt_q;
    logic [7:0]             duty_q, duty_d;
    logic [7:0]             tgt_q, tgt_d;
    logic [7:0]             step_q, step_d;
    logic [7:0]             hold_q, hold_d;
    logic [7:0]             hc_q, hc_d;
    logic                   done_q, done_d;

    logic [8:0]             sum9, dif9;
    logic [7:0]             duty_nxt;

    // Free-running period counter; wraps naturally at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_q + PERIOD_BITS'(1);
    end

    assign period_end = &cnt_q;

    // Next duty value, computed in 9 bits so the step can neither
    // overshoot the target nor wrap through 0 or 255.
    always_comb begin
        sum9 = {1'b0, duty_q} + {1'b0, step_q};
        dif9 = {1'b0, duty_q} - {1'b0, step_q};
        if (tgt_q > duty_q)
            duty_nxt = (sum9 > {1'b0, tgt_q}) ? tgt_q : sum9[7:0];
        else
            duty_nxt = (dif9[8] || (dif9[7:0] < tgt_q)) ? tgt_q : dif9[7:0];
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            duty_q  <= INIT_DUTY;
            tgt_q   <= '0;
            step_q  <= 8'd1;
            hold_q  <= '0;
            hc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            hc_q    <= hc_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: command acceptance in IDLE, paced stepping in RAMP.
    // abort takes priority over a coincident period boundary.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        hold_d  = hold_q;
        hc_d    = hc_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    tgt_d  = cmd.cmd_target;
                    step_d = (cmd.cmd_step == 8'd0) ? 8'd1 : cmd.cmd_step;
                    hold_d = cmd.cmd_hold;
                    hc_d   = '0;
                    if (cmd.cmd_target == duty_q) done_d  = 1'b1;
                    else                          state_d = RAMP;
                end
            end
            RAMP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (period_end) begin
                    if (hc_q != 8'd0) begin
                        hc_d = hc_q - 8'd1;
                    end else begin
                        hc_d   = hold_q;
                        duty_d = duty_nxt;
                        if (duty_nxt == tgt_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd.cmd_ready = (state_q == IDLE);
    assign busy          = (state_q == RAMP);
    assign duty_out      = duty_q;
    assign done          = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Randomised + directed bench for pwm_ramp_ctrl with a 16-clk period.
// The reference model schedules updates by absolute cycle number:
// the first update lands on the first period end after acceptance and
// later ones every (hold+1)*16 cycles after that.
module tb_pwm_ramp_ctrl;
    localparam int PB  = 4;
    localparam int PER = 1 << PB;

    logic       clk = 1'b0;
    logic       reset;
    logic       abort;
    logic [7:0] duty_out;
    logic       period_end, busy, done;

    pwm_ramp_ctrl_if ifc();

    pwm_ramp_ctrl #(.PERIOD_BITS(PB), .INIT_DUTY(8'd0)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (ifc.slave),
        .abort      (abort),
        .duty_out   (duty_out),
        .period_end (period_end),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int n;          // cycle index since reset release
    int mduty;
    bit mbusy;
    bit mdone;
    int mtgt, mstep, mhold, mp0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, n);
        end
    endtask

    // Check the current cycle, drive inputs for it, advance the model
    // across the next edge.
    task automatic tick(input bit v, input int t, input int s, input int h, input bit a);
        bit nd;
        chk("duty",  32'(duty_out),      32'(mduty));
        chk("busy",  32'(busy),          32'(mbusy));
        chk("ready", 32'(ifc.cmd_ready), 32'(!mbusy));
        chk("done",  32'(done),          32'(mdone));
        chk("pend",  32'(period_end),    32'((n % PER) == PER - 1));
        ifc.cmd_valid  = v;
        ifc.cmd_target = 8'(t);
        ifc.cmd_step   = 8'(s);
        ifc.cmd_hold   = 8'(h);
        abort          = a;
        nd = 1'b0;
        if (!mbusy) begin
            if (v) begin
                mtgt  = t;
                mstep = (s == 0) ? 1 : s;
                mhold = h;
                if (t == mduty) nd = 1'b1;
                else begin
                    mbusy = 1'b1;
                    mp0   = n + (PER - 1) - (n % PER);
                    if (mp0 <= n) mp0 += PER;
                end
            end
        end else if (a) begin
            mbusy = 1'b0;
        end else if ((n % PER) == PER - 1 && ((n - mp0) % (PER * (mhold + 1))) == 0) begin
            if (mtgt > mduty) mduty = (mduty + mstep > mtgt) ? mtgt : mduty + mstep;
            else              mduty = (mduty - mstep < mtgt) ? mtgt : mduty - mstep;
            if (mduty == mtgt) begin
                mbusy = 1'b0;
                nd    = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        n++;
        mdone = nd;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick(0, 0, 0, 0, 0);
    endtask

    // Issue one command from IDLE and run it to completion.
    task automatic send(input int t, input int s, input int h);
        int k;
        tick(1, t, s, h, 0);
        k = 0;
        while ((mbusy || mdone) && k < 20000) begin
            tick(0, 0, 0, 0, 0);
            k++;
        end
        if (k >= 20000) chk("send_timeout", 32'(k), 32'(0));
        idle(3);
    endtask

    task automatic model_reset();
        n = 0; mduty = 0; mbusy = 0; mdone = 0;
        mtgt = 0; mstep = 1; mhold = 0; mp0 = 0;
    endtask

    initial begin
        int k;
        ifc.cmd_valid = 0; ifc.cmd_target = 0; ifc.cmd_step = 0; ifc.cmd_hold = 0;
        abort = 0;
        reset = 1;
        model_reset();
        #12;
        chk("rst_duty",  32'(duty_out),      32'(0));
        chk("rst_ready", 32'(ifc.cmd_ready), 32'(1));
        chk("rst_busy",  32'(busy),          32'(0));
        chk("rst_pend",  32'(period_end),    32'(0));
        chk("rst_done",  32'(done),          32'(0));
        #10 reset = 0;

        // idle: period_end only at cycles 15 and 31
        idle(40);

        // 0 -> 10 step 4: 4, 8, 10
        send(10, 4, 0);
        chk("ramp_up_end", 32'(duty_out), 32'(10));

        // 10 -> 0 step 3 hold 1, valid held high during the ramp
        tick(1, 0, 3, 1, 0);
        k = 0;
        while (mbusy && k < 2000) begin
            tick(1, 0, 3, 1, 0);
            k++;
        end
        if (k >= 2000) chk("hold_timeout", 32'(k), 32'(0));
        tick(1, 0, 3, 1, 0);   // re-accepted at done: same target
        idle(4);
        chk("ramp_dn_end", 32'(duty_out), 32'(0));

        // same-target and step 0
        send(0, 0, 0);
        send(3, 0, 0);
        chk("step0_end", 32'(duty_out), 32'(3));

        // saturation
        send(250, 255, 0);
        send(255, 200, 0);
        chk("sat_hi", 32'(duty_out), 32'(255));
        send(5, 255, 0);
        send(0, 200, 0);
        chk("sat_lo", 32'(duty_out), 32'(0));

        // abort on the period end that would take 20 -> 30
        tick(1, 200, 10, 0, 0);
        k = 0;
        while (!(mduty == 20 && (n % PER) == PER - 1) && k < 500) begin
            tick(0, 0, 0, 0, 0);
            k++;
        end
        if (k >= 500) chk("abort_timeout", 32'(k), 32'(0));
        tick(0, 0, 0, 0, 1);
        chk("abort_duty",  32'(duty_out),      32'(20));
        chk("abort_ready", 32'(ifc.cmd_ready), 32'(1));
        idle(40);

        // async reset mid-ramp
        tick(1, 200, 50, 0, 0);
        k = 0;
        while (mduty == 20 && k < 100) begin
            tick(0, 0, 0, 0, 0);
            k++;
        end
        idle(5);
        #2 reset = 1;
        #1;
        chk("mid_rst_duty",  32'(duty_out),      32'(0));
        chk("mid_rst_busy",  32'(busy),          32'(0));
        chk("mid_rst_ready", 32'(ifc.cmd_ready), 32'(1));
        chk("mid_rst_done",  32'(done),          32'(0));
        @(posedge clk);
        #2 reset = 0;
        model_reset();
        idle(20);

        // randomised commands and aborts
        for (int i = 0; i < 4000; i++) begin
            bit v, a;
            int t, s, h;
            v = ($urandom % 4) == 0;
            t = $urandom % 256;
            case ($urandom % 4)
                0:       s = $urandom % 3;
                1:       s = $urandom_range(200, 255);
                default: s = $urandom_range(20, 120);
            endcase
            h = $urandom % 3;
            a = mbusy && (($urandom % 300) == 0);
            tick(v, t, s, h, a);
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Sequencer that drives the 8-bit duty input of the free-running PWM generator.
- Accepts ramp commands (target, step, hold) over a valid/ready handshake.
- Moves its duty output toward the target in saturating steps, changing duty only at PWM period boundaries so no period is glitched.
- Runs a period counter identical in width to the PWM counter and exports the period-boundary strobe.

Parameters:
- PERIOD_BITS, 17, width of the internal period counter; PWM period = 2^PERIOD_BITS clk cycles.
- INIT_DUTY, 0, duty_out value after reset (8-bit).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_target  input  8  final duty value
- cmd_step  input  8  duty increment per update; 0 is treated as 1
- cmd_hold  input  8  extra whole periods to wait between updates
- abort  input  1  stop the active ramp and freeze duty
- duty_out  output  8  duty value for the PWM generator, registered
- period_end  output  1  high during the last clk of each period (counter == all-ones)
- busy  output  1  ramp in progress
- done  output  1  one-cycle completion pulse, registered

Behaviour:
- Reset (async, high):
  - period counter = 0; state = IDLE; duty_out = INIT_DUTY; done = 0.
  - Outputs during and after reset: cmd_ready = 1, busy = 0, period_end = 0.
  - Reset mid-ramp discards the command immediately, with no done pulse.
- Period counter:
  - PERIOD_BITS wide, increments every clk, wraps all-ones -> 0 naturally.
  - period_end is decoded from the counter register.
  - Any duty_out change occurs on the edge where the counter wraps to 0.
- States: IDLE, RAMP.
- IDLE:
  - cmd_ready = 1, busy = 0.
  - Accept on cmd_valid & cmd_ready: latch target, step (0 -> 1) and hold; clear the hold counter hc to 0.
  - If target == duty_out: stay IDLE and pulse done in the next cycle.
  - Otherwise: go to RAMP.
  - abort is ignored in IDLE.
- RAMP:
  - cmd_ready = 0, busy = 1; cmd_valid is ignored.
  - Each period_end cycle:
    - If hc != 0: hc <= hc - 1.
    - Else: hc <= hold and duty_out steps toward target.
    - Step up: new = min(duty + step, target).
    - Step down: new = max(duty - step, target).
    - Compute in 9 bits; never overshoot, never wrap past 0 or 255.
    - If new == target: go to IDLE and done = 1 in the following cycle.
  - Update cadence: the first update occurs at the first period_end after acceptance; subsequent updates occur every hold+1 periods.
- abort in RAMP:
  - Go to IDLE at the next edge; duty_out keeps its current value; no done pulse.
  - If abort coincides with period_end, abort wins and that step is not applied.
- Handshake:
  - A command is consumed only on an edge with cmd_valid & cmd_ready.
  - cmd_ready rises the cycle after the edge that returns to IDLE, i.e. coincident with done.
  - The controller can accept a new command in that same cycle.
- done:
  - Exactly one cycle wide.
  - Never asserted for aborted commands or commands interrupted by reset.

Test Plan (PERIOD_BITS = 4, so the period is 16 clk):
- Reset, then idle for 40 clk -> duty_out = 0, cmd_ready = 1, busy = 0, done = 0; period_end high at cycles 15 and 31 only.
- From duty 0, command target = 10, step = 4, hold = 0 -> duty_out = 4, 8, 10 at three consecutive counter wraps; done pulses once in the cycle after the wrap to 10; busy falls and cmd_ready rises simultaneously.
- From duty 10, command target = 0, step = 3, hold = 1 -> duty_out = 7, 4, 1, 0, one update every 2 periods; cmd_valid held high during the ramp is not accepted until done.
- Command target equal to current duty (e.g. 0 -> 0) -> no duty change; done the cycle after acceptance; step = 0 with 0 -> 3 ramps 1, 2, 3.
- Saturation: from 250, target = 255, step = 200 -> duty_out = 255 (no wrap); from 5, target = 0, step = 200 -> duty_out = 0.
- From 0, target = 200, step = 10: abort asserted on the period_end cycle where duty would go 20 -> 30 -> duty stays 20, no done, cmd_ready = 1 next cycle. Async reset asserted mid-clock during a ramp -> duty_out = 0 immediately, state IDLE, no done.
